// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared constants for the debug-monitor memory controller:
// jdo field positions, register bit indices and the status-word packer.
package cpu_debug_ocimem_pkg;

  localparam int JDO_W         = 38;
  localparam int JDO_RD        = 35;
  localparam int JDO_GO        = 34;
  localparam int JDO_CLR       = 33;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

  localparam int REG_READY = 0;
  localparam int REG_ERROR = 1;
  localparam int REG_CLRGO = 2;

  function automatic logic [31:0] reg_word(
    input logic go,
    input logic err,
    input logic rdy
  );
    logic [31:0] w;
    w            = '0;
    w[REG_READY] = rdy;
    w[REG_ERROR] = err;
    w[2]         = go;
    return w;
  endfunction

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port 32-bit debug RAM with byte enables and registered read.
// Ports: clk, en/we/be/addr/wdata request, rdata valid the cycle after en.
module cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug-monitor memory controller: JTAG strobes and a CPU Avalon slave
// share one debug RAM; also holds monitor go/ready/error handshake bits.
// Ports: clk/reset, jdo + ocimem strobes (JTAG), Avalon slave
// (address/read/write/writedata/byteenable/debugaccess/readdata/
// waitrequest), MonDReg/MonAReg/monitor_* back to the debug wrapper.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter bit INIT_GO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  import cpu_debug_ocimem_pkg::*;

  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              go_q, go_d;
  logic              jrd_q;
  logic              rd_pend_q, rd_ram_q;
  logic [31:0]       rd_hold_q, rd_hold_d;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // JTAG strobes, a > b > no-action
  logic ja, jb, jn, j_rd, j_acc;
  logic [ADDR_W-1:0] jdo_addr, j_addr;

  assign ja = take_action_ocimem_a && !reset;
  assign jb = take_action_ocimem_b && !take_action_ocimem_a && !reset;
  assign jn = take_no_action_ocimem_a && !take_action_ocimem_a
           && !take_action_ocimem_b && !reset;

  assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign j_rd     = (ja && jdo[JDO_RD]) || jn;
  assign j_acc    = j_rd || jb;
  assign j_addr   = ja ? jdo_addr : mon_a_q;

  // CPU side; JTAG owns the RAM port whenever it needs it
  logic ram_sel, reg0_sel, c_wr, c_rd;
  logic c_ram_wr, c_rd_go, c_ram_rd, reg_wr;

  assign ram_sel  = !address[ADDR_W];
  assign reg0_sel = address[ADDR_W] && (address[ADDR_W-1:0] == '0);
  assign c_wr     = write && !reset;
  assign c_rd     = read && !write && !reset;
  assign c_ram_wr = c_wr && ram_sel && debugaccess && !j_acc;
  assign c_rd_go  = c_rd && !rd_pend_q && (!ram_sel || !j_acc);
  assign c_ram_rd = c_rd_go && ram_sel && debugaccess;
  assign reg_wr   = c_wr && reg0_sel;

  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  assign ram_en    = j_acc || c_ram_wr || c_ram_rd;
  assign ram_we    = jb || c_ram_wr;
  assign ram_be    = jb ? 4'hF : byteenable;
  assign ram_addr  = j_acc ? j_addr : address[ADDR_W-1:0];
  assign ram_wdata = jb ? jdo[JDO_WDATA_LSB +: 32] : writedata;

  cpu_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    mon_a_d = mon_a_q;
    if (ja)             mon_a_d = jdo_addr;
    else if (jb || jn)  mon_a_d = mon_a_q + 1'b1;

    mon_d_d = jrd_q ? ram_rdata : mon_d_q;

    // JTAG clear first so a same-cycle CPU set wins
    rdy_d = rdy_q;
    err_d = err_q;
    if (ja && jdo[JDO_CLR]) begin
      rdy_d = 1'b0;
      err_d = 1'b0;
    end
    if (reg_wr && writedata[REG_READY]) rdy_d = 1'b1;
    if (reg_wr && writedata[REG_ERROR]) err_d = 1'b1;

    // CPU clear first so a same-cycle JTAG go wins
    go_d = go_q;
    if (reg_wr && writedata[REG_CLRGO]) go_d = 1'b0;
    if (ja && jdo[JDO_GO])              go_d = 1'b1;

    rd_hold_d = '0;
    if (c_rd_go && reg0_sel) rd_hold_d = reg_word(go_q, err_q, rdy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      go_q      <= INIT_GO;
      jrd_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_ram_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      go_q      <= go_d;
      jrd_q     <= j_rd;
      rd_pend_q <= c_rd_go;
      rd_ram_q  <= c_ram_rd;
      rd_hold_q <= rd_hold_d;
    end
  end

  always_comb begin
    waitrequest = 1'b0;
    if (reset)      waitrequest = 1'b1;
    else if (write) waitrequest = ram_sel && j_acc;
    else if (read)  waitrequest = !rd_pend_q;
  end

  always_comb begin
    readdata = '0;
    if (!reset && rd_pend_q) readdata = rd_ram_q ? ram_rdata : rd_hold_q;
  end

  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign monitor_go    = go_q;

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Self-checking bench for cpu_debug_ocimem_ctrl: behavioural model
// plus directed JTAG/CPU vectors with hand-computed expectations.
module tb_cpu_debug_ocimem_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          ta, tb, tn;
  logic [AW:0]   address;
  logic          read, write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic          debugaccess;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error, monitor_go;

  cpu_debug_ocimem_ctrl #(.ADDR_W(AW), .INIT_GO(1'b0)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_action_ocimem_b    (tb),
    .take_no_action_ocimem_a (tn),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [31:0] d; } pend_t;

  logic [31:0]   mmem [int];
  pend_t         pend [$];
  logic [AW-1:0] m_ma;
  logic [31:0]   m_md;
  bit            m_md_known;
  bit            m_rdy, m_err, m_go;
  bit            m_busy;
  int            k = 0;
  bit            chk_on = 0;

  function automatic logic [31:0] mrd(input logic [AW-1:0] a);
    if (mmem.exists(int'(a))) return mmem[int'(a)];
    return 'x;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ma = '0; m_md = '0; m_md_known = 1;
      m_rdy = 0; m_err = 0; m_go = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due == k) begin
        m_md = pend[0].d;
        m_md_known = !$isunknown(pend[0].d);
        void'(pend.pop_front());
      end
      m_busy = ta ? jdo[35] : (tb || tn);
      if (write && !address[AW] && debugaccess && !m_busy) begin
        logic [31:0] w;
        w = mrd(address[AW-1:0]);
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) w[8*i +: 8] = writedata[8*i +: 8];
        mmem[int'(address[AW-1:0])] = w;
      end
      if (ta && jdo[33]) begin m_rdy = 0; m_err = 0; end
      if (write && address == 9'h100) begin
        if (writedata[0]) m_rdy = 1;
        if (writedata[1]) m_err = 1;
        if (writedata[2]) m_go = 0;
      end
      if (ta && jdo[34]) m_go = 1;
      if (ta) begin
        m_ma = jdo[24:17];
        if (jdo[35]) pend.push_back('{k + 1, mrd(m_ma)});
      end else if (tb) begin
        mmem[int'(m_ma)] = jdo[34:3];
        m_ma = m_ma + 1'b1;
      end else if (tn) begin
        pend.push_back('{k + 1, mrd(m_ma)});
        m_ma = m_ma + 1'b1;
      end
    end
    k++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (reset) begin
        chk("m_rst_wait", waitrequest, 1);
        chk("m_rst_rdata", readdata, 0);
      end
      chk("m_MonAReg", MonAReg, m_ma);
      if (m_md_known) chk("m_MonDReg", MonDReg, m_md);
      chk("m_ready", monitor_ready, m_rdy);
      chk("m_error", monitor_error, m_err);
      chk("m_go", monitor_go, m_go);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] a, input bit rd,
                          input bit go, input bit clr);
    jdo = {2'b0, rd, go, clr, 8'b0, a, 17'b0};
    ta = 1;
    tick;
    ta = 0;
    jdo = '0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = {3'b0, d, 3'b0};
    tb = 1;
    tick;
    tb = 0;
    jdo = '0;
  endtask

  task automatic jread(input logic [7:0] a, input logic [31:0] exp,
                       input string name);
    strobe_a(a, 1, 0, 0);
    tick;
    chk(name, MonDReg, exp);
  endtask

  task automatic cpu_write_finish(input int exp_waits, input string name);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) done = 1;
      else begin n++; tick; end
    end
    chk(name, n, exp_waits);
    if (done) tick;
    write = 0;
  endtask

  task automatic cpu_write(input logic [AW:0] a, input logic [31:0] d,
                           input logic [3:0] be, input bit dbg,
                           input int exp_waits, input string name);
    address = a; writedata = d; byteenable = be;
    debugaccess = dbg; write = 1;
    cpu_write_finish(exp_waits, name);
  endtask

  task automatic cpu_read_finish(input logic [31:0] exp, input int exp_waits,
                                 input string name);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        done = 1;
        chk({name, "_data"}, readdata, exp);
      end else begin
        n++; tick;
      end
    end
    chk({name, "_waits"}, n, exp_waits);
    if (done) tick;
    read = 0;
  endtask

  task automatic cpu_read(input logic [AW:0] a, input bit dbg,
                          input logic [31:0] exp, input string name);
    address = a; debugaccess = dbg; read = 1;
    cpu_read_finish(exp, 1, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; jdo = '0; ta = 0; tb = 0; tn = 0;
    address = '0; read = 0; write = 0; writedata = '0;
    byteenable = '0; debugaccess = 0;
    tick;
    chk_on = 1;
    tick;
    chk("rst_wait", waitrequest, 1);
    chk("rst_rdata", readdata, 0);
    chk("rst_mond", MonDReg, 0);
    chk("rst_go", monitor_go, 0);
    reset = 0;
    tick;

    // 1: write then read back through JTAG
    strobe_a(8'h05, 0, 0, 0);
    chk("t1_ma_a", MonAReg, 8'h05);
    strobe_b(32'hDEADBEEF);
    chk("t1_ma_inc", MonAReg, 8'h06);
    strobe_a(8'h05, 1, 0, 0);
    chk("t1_ma_rd", MonAReg, 8'h05);
    chk("t1_md_early", MonDReg, 0);
    tick;
    chk("t1_md", MonDReg, 32'hDEADBEEF);

    // 2: address wrap
    strobe_a(8'hFF, 0, 0, 0);
    strobe_b(32'h11);
    strobe_b(32'h22);
    chk("t2_ma", MonAReg, 8'h01);
    jread(8'hFF, 32'h11, "t2_rd_ff");
    jread(8'h00, 32'h22, "t2_rd_00");

    // streaming read: ff then 00
    strobe_a(8'hFF, 0, 0, 0);
    strobe_n(); tick;
    chk("t2_stream0", MonDReg, 32'h11);
    strobe_n(); tick;
    chk("t2_stream1", MonDReg, 32'h22);
    chk("t2_stream_ma", MonAReg, 8'h01);

    // 3: CPU byte-enable write, debugaccess gating
    cpu_write(9'h010, 32'h0, 4'hF, 1, 0, "t3_clr");
    cpu_write(9'h010, 32'h12345678, 4'b0011, 1, 0, "t3_wr");
    cpu_read(9'h010, 1, 32'h00005678, "t3_rd");
    cpu_write(9'h010, 32'hAAAAAAAA, 4'hF, 0, 0, "t3_wr_nodbg");
    cpu_read(9'h010, 1, 32'h00005678, "t3_rd2");
    cpu_read(9'h010, 0, 32'h0, "t3_rd_nodbg");

    // 4: CPU read collides with JTAG write
    strobe_a(8'h00, 0, 0, 0);
    address = 9'h010; debugaccess = 1; read = 1;
    jdo = {3'b0, 32'hCAFEF00D, 3'b0}; tb = 1;
    @(negedge clk);
    chk("t4_wait0", waitrequest, 1);
    tick;
    tb = 0; jdo = '0;
    cpu_read_finish(32'h00005678, 1, "t4_rd");
    jread(8'h00, 32'hCAFEF00D, "t4_jwr");

    // CPU write collides with JTAG write
    address = 9'h020; writedata = 32'h0BADCAFE; byteenable = 4'hF;
    debugaccess = 1; write = 1;
    jdo = {3'b0, 32'h13579BDF, 3'b0}; tb = 1;
    @(negedge clk);
    chk("t4_wwait0", waitrequest, 1);
    tick;
    tb = 0; jdo = '0;
    cpu_write_finish(0, "t4_wr");
    jread(8'h20, 32'h0BADCAFE, "t4_cpu_wr");
    jread(8'h00, 32'h13579BDF, "t4_j_wr");

    // 5: monitor handshake
    strobe_a(8'h00, 0, 1, 0);
    chk("t5_go", monitor_go, 1);
    cpu_write(9'h100, 32'h3, 4'hF, 1, 0, "t5_set");
    chk("t5_rdy", monitor_ready, 1);
    chk("t5_err", monitor_error, 1);
    cpu_read(9'h100, 1, 32'h7, "t5_reg7");
    cpu_write(9'h100, 32'h4, 4'hF, 1, 0, "t5_clrgo");
    chk("t5_go0", monitor_go, 0);
    cpu_read(9'h100, 1, 32'h3, "t5_reg3");
    strobe_a(8'h00, 0, 0, 1);
    chk("t5_rdy0", monitor_ready, 0);
    chk("t5_err0", monitor_error, 0);
    cpu_write(9'h101, 32'h7, 4'hF, 1, 0, "t5_other_wr");
    cpu_read(9'h101, 1, 32'h0, "t5_other_rd");
    chk("t5_other_rdy", monitor_ready, 0);

    // same-cycle conflicts: CPU set beats clear, JTAG go beats clear-go
    address = 9'h100; writedata = 32'h7; byteenable = 4'hF;
    debugaccess = 1; write = 1;
    jdo = {2'b0, 1'b0, 1'b1, 1'b1, 8'b0, 8'h00, 17'b0}; ta = 1;
    @(negedge clk);
    chk("t5_conf_wait", waitrequest, 0);
    tick;
    write = 0; ta = 0; jdo = '0;
    chk("t5_conf_rdy", monitor_ready, 1);
    chk("t5_conf_err", monitor_error, 1);
    chk("t5_conf_go", monitor_go, 1);

    // 6: reset right after a JTAG read strobe
    strobe_a(8'h20, 1, 0, 0);
    reset = 1;
    @(negedge clk);
    chk("t6_wait", waitrequest, 1);
    chk("t6_rdata", readdata, 0);
    tick;
    reset = 0;
    chk("t6_md", MonDReg, 0);
    chk("t6_ma", MonAReg, 0);
    chk("t6_rdy", monitor_ready, 0);
    chk("t6_go", monitor_go, 0);
    tick;
    chk("t6_md2", MonDReg, 0);
    jread(8'h20, 32'h0BADCAFE, "t6_rd");
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic strobe_n();
    tn = 1;
    tick;
    tn = 0;
  endtask

endmodule
